// File: rtl/xrv1_wb_arb_if.sv
// Writeback arbiter bus: three result producers in, one register-file write port out.
interface xrv1_wb_arb_if #(
  parameter int unsigned DATA_WIDTH_P = 32,
  parameter int unsigned ITAG_WIDTH_P = 4
);
  logic                    alu_res_vld_i;
  logic [DATA_WIDTH_P-1:0] alu_res_i;
  logic [ITAG_WIDTH_P-1:0] alu_itag_i;

  logic                    mul_res_vld_i;
  logic [DATA_WIDTH_P-1:0] mul_res_i;
  logic [ITAG_WIDTH_P-1:0] mul_itag_i;
  logic                    mul_wb_rdy_o;

  logic                    div_res_vld_i;
  logic [DATA_WIDTH_P-1:0] div_res_i;
  logic [ITAG_WIDTH_P-1:0] div_itag_i;
  logic                    div_wb_rdy_o;

  logic                    wb_vld_o;
  logic [DATA_WIDTH_P-1:0] wb_data_o;
  logic [ITAG_WIDTH_P-1:0] wb_itag_o;
  logic [1:0]              wb_src_o;

  // Producer / register-file side.
  modport master (
    output alu_res_vld_i, alu_res_i, alu_itag_i,
    output mul_res_vld_i, mul_res_i, mul_itag_i,
    output div_res_vld_i, div_res_i, div_itag_i,
    input  mul_wb_rdy_o, div_wb_rdy_o,
    input  wb_vld_o, wb_data_o, wb_itag_o, wb_src_o
  );

  // Arbiter side.
  modport slave (
    input  alu_res_vld_i, alu_res_i, alu_itag_i,
    input  mul_res_vld_i, mul_res_i, mul_itag_i,
    input  div_res_vld_i, div_res_i, div_itag_i,
    output mul_wb_rdy_o, div_wb_rdy_o,
    output wb_vld_o, wb_data_o, wb_itag_o, wb_src_o
  );
endinterface

// File: rtl/xrv1_wb_arb.sv
// Writeback arbiter: ALU has absolute priority; MUL and DIV results are queued
// in per-source FIFOs and drained round-robin onto a registered write port.
module xrv1_wb_arb #(
  parameter int unsigned DATA_WIDTH_P = 32,
  parameter int unsigned ITAG_WIDTH_P = 4,
  parameter int unsigned FIFO_DEPTH_P = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  xrv1_wb_arb_if.slave bus
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH_P);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned NSRC = 2;  // index 0 = MUL, 1 = DIV

  typedef struct packed {
    logic [DATA_WIDTH_P-1:0] data;
    logic [ITAG_WIDTH_P-1:0] itag;
  } entry_t;

  typedef enum logic {RR_MUL = 1'b0, RR_DIV = 1'b1} rr_e;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MUL = 2'd1, SRC_DIV = 2'd2} src_e;

  entry_t                  mem_q    [NSRC][FIFO_DEPTH_P];
  logic   [AW-1:0]         wr_ptr_q [NSRC];
  logic   [AW-1:0]         wr_ptr_d [NSRC];
  logic   [AW-1:0]         rd_ptr_q [NSRC];
  logic   [AW-1:0]         rd_ptr_d [NSRC];
  logic   [CW-1:0]         cnt_q    [NSRC];
  logic   [CW-1:0]         cnt_d    [NSRC];
  entry_t                  push_ent [NSRC];
  logic   [NSRC-1:0]       full, nempty, push, pop;
  logic                    sel;
  entry_t                  sel_ent;
  rr_e                     rr_q, rr_d;
  logic                    wb_vld_q, wb_vld_d;
  logic [DATA_WIDTH_P-1:0] wb_data_q, wb_data_d;
  logic [ITAG_WIDTH_P-1:0] wb_itag_q, wb_itag_d;
  src_e                    wb_src_q, wb_src_d;

  // FIFO status and push qualification; ready depends on the current count only.
  always_comb begin
    push_ent[0] = '{data: bus.mul_res_i, itag: bus.mul_itag_i};
    push_ent[1] = '{data: bus.div_res_i, itag: bus.div_itag_i};
    for (int unsigned s = 0; s < NSRC; s++) begin
      full[s]   = (cnt_q[s] == CW'(FIFO_DEPTH_P));
      nempty[s] = (cnt_q[s] != '0);
    end
    push[0] = bus.mul_res_vld_i && !full[0];
    push[1] = bus.div_res_vld_i && !full[1];
  end

  // Grant selection and next output-register contents.
  always_comb begin
    pop       = '0;
    sel       = 1'b0;
    sel_ent   = '0;
    rr_d      = rr_q;
    wb_vld_d  = 1'b0;
    wb_data_d = wb_data_q;
    wb_itag_d = wb_itag_q;
    wb_src_d  = wb_src_q;
    if (bus.alu_res_vld_i) begin
      wb_vld_d  = 1'b1;
      wb_data_d = bus.alu_res_i;
      wb_itag_d = bus.alu_itag_i;
      wb_src_d  = SRC_ALU;
    end else if (nempty != '0) begin
      // With both queues occupied the pointer decides; otherwise the lone one wins.
      sel       = (&nempty) ? (rr_q == RR_DIV) : nempty[1];
      pop[sel]  = 1'b1;
      rr_d      = sel ? RR_MUL : RR_DIV;
      sel_ent   = mem_q[sel][rd_ptr_q[sel]];
      wb_vld_d  = 1'b1;
      wb_data_d = sel_ent.data;
      wb_itag_d = sel_ent.itag;
      wb_src_d  = sel ? SRC_DIV : SRC_MUL;
    end
    if (flush_i) begin
      pop       = '0;
      rr_d      = rr_q;
      wb_vld_d  = 1'b0;
      wb_data_d = wb_data_q;
      wb_itag_d = wb_itag_q;
      wb_src_d  = wb_src_q;
    end
  end

  // FIFO pointer and occupancy update; flush empties both queues.
  always_comb begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + AW'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + AW'(pop[s]);
      cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      if (flush_i) begin
        wr_ptr_d[s] = '0;
        rd_ptr_d[s] = '0;
        cnt_d[s]    = '0;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked by the counts.
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (push[s] && !flush_i && rst_i) begin
        mem_q[s][wr_ptr_q[s]] <= push_ent[s];
      end
    end
  end

  // Control state and registered write port with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      rr_q      <= RR_MUL;
      wb_vld_q  <= 1'b0;
      wb_data_q <= '0;
      wb_itag_q <= '0;
      wb_src_q  <= SRC_ALU;
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      rr_q      <= rr_d;
      wb_vld_q  <= wb_vld_d;
      wb_data_q <= wb_data_d;
      wb_itag_q <= wb_itag_d;
      wb_src_q  <= wb_src_d;
    end
  end

  assign bus.mul_wb_rdy_o = !full[0];
  assign bus.div_wb_rdy_o = !full[1];
  assign bus.wb_vld_o     = wb_vld_q;
  assign bus.wb_data_o    = wb_data_q;
  assign bus.wb_itag_o    = wb_itag_q;
  assign bus.wb_src_o     = wb_src_q;
endmodule
